serial_pattern_tx: RTL and testbench

//  Moore-style serial pattern transmitter: accepts a parallel word + bit count over a valid/ready

---
 rtl/serial_pattern_tx.sv | 101 ++++++++++
 tb/tb_serial_pattern_tx.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: MSB-first serial word transmitter with valid/ready load port and registered outputs.
// Optional TX_REPEAT_EN adds repeat_en to resend the captured word back-to-back.
module serial_pattern_tx #(
    parameter int WIDTH      = 8,
    parameter int LEN_W      = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LEN_W-1:0] load_len,
`ifdef TX_REPEAT_EN
    input  logic             repeat_en,
`endif
    output logic             w,
    output logic             w_valid,
    output logic             busy,
    output logic             done
);
    localparam int GW = $clog2(GAP_CYCLES + 2);
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
    state_t           state, state_d;
    logic [WIDTH-1:0] sh, sh_d;
    logic [LEN_W-1:0] cnt, cnt_d, len_n;
    logic [GW-1:0]    gcnt, gcnt_d;
    logic             done_d;
`ifdef TX_REPEAT_EN
    logic [WIDTH-1:0] word;
    logic [LEN_W-1:0] len_q;
`endif
    always_comb begin
        len_n   = (load_len == '0 || load_len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : load_len;
        state_d = state;
        sh_d    = sh;
        cnt_d   = cnt;
        gcnt_d  = gcnt;
        done_d  = 1'b0;
        case (state)
            IDLE: if (load_valid) begin
                state_d = SHIFT;
                sh_d    = load_data << (LEN_W'(WIDTH) - len_n);
                cnt_d   = len_n;
            end
            SHIFT: begin
                sh_d  = sh << 1;
                cnt_d = cnt - 1'b1;
                if (cnt == LEN_W'(1)) begin
                    done_d = 1'b1;
`ifdef TX_REPEAT_EN
                    if (repeat_en) begin
                        sh_d  = word;
                        cnt_d = len_q;
                    end else
`endif
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        gcnt_d  = GW'(GAP_CYCLES - 1);
                    end else
                        state_d = IDLE;
                end
            end
            GAP: if (gcnt == '0) state_d = IDLE; else gcnt_d = gcnt - 1'b1;
            default: state_d = IDLE;
        endcase
    end
    // outputs are registered from next-state values so w never follows an input combinationally
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            state      <= IDLE;
            sh         <= '0;
            cnt        <= '0;
            gcnt       <= '0;
            w          <= 1'b0;
            w_valid    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b1;
`ifdef TX_REPEAT_EN
            word       <= '0;
            len_q      <= '0;
`endif
        end else begin
            state      <= state_d;
            sh         <= sh_d;
            cnt        <= cnt_d;
            gcnt       <= gcnt_d;
            w          <= state_d == SHIFT && sh_d[WIDTH-1];
            w_valid    <= state_d == SHIFT;
            busy       <= state_d != IDLE;
            done       <= done_d;
            load_ready <= state_d == IDLE;
`ifdef TX_REPEAT_EN
            if (state == IDLE && load_valid) begin
                word  <= sh_d;
                len_q <= cnt_d;
            end
`endif
        end
endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx: scoreboard bench; instance 0 uses GAP_CYCLES=1, instance 1 uses GAP_CYCLES=0.
module tb_serial_pattern_tx;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [1:0] lv = '0;
    logic [7:0] ld [2];
    logic [3:0] ll [2];
    logic [1:0] rpt = '0;
    logic [1:0] load_ready_s, w_s, w_valid_s, busy_s, done_s;
    logic [1:0] sbq [2][$];
    logic [1:0] pend = '0;
    logic [1:0] it;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    serial_pattern_tx #(.WIDTH(8), .LEN_W(4), .GAP_CYCLES(1)) dut0 (
        .clk(clk), .resetn(resetn), .load_valid(lv[0]), .load_ready(load_ready_s[0]),
        .load_data(ld[0]), .load_len(ll[0]),
`ifdef TX_REPEAT_EN
        .repeat_en(rpt[0]),
`endif
        .w(w_s[0]), .w_valid(w_valid_s[0]), .busy(busy_s[0]), .done(done_s[0]));

    serial_pattern_tx #(.WIDTH(8), .LEN_W(4), .GAP_CYCLES(0)) dut1 (
        .clk(clk), .resetn(resetn), .load_valid(lv[1]), .load_ready(load_ready_s[1]),
        .load_data(ld[1]), .load_len(ll[1]),
`ifdef TX_REPEAT_EN
        .repeat_en(rpt[1]),
`endif
        .w(w_s[1]), .w_valid(w_valid_s[1]), .busy(busy_s[1]), .done(done_s[1]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input int k, input logic [7:0] e, input int n);
        for (int i = n - 1; i >= 0; i--) sbq[k].push_back({i == 0, e[i]});
    endtask

    // called just after a negedge; returns at the negedge of the first bit cycle
    task automatic send(input int k, input logic [7:0] d, input logic [3:0] l,
                        input logic [7:0] e, input int n);
        int t = 0;
        while (!load_ready_s[k] && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("ready_wait", {31'b0, load_ready_s[k]}, 1);
        push(k, e, n);
        ld[k] = d;
        ll[k] = l;
        lv[k] = 1'b1;
        @(negedge clk);
        lv[k] = 1'b0;
        chk("first_bit_lat", {31'b0, w_valid_s[k]}, 1);
        chk("ready_low", {31'b0, load_ready_s[k]}, 0);
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!resetn) pend[k] = 1'b0;
            else begin
                chk("done", {31'b0, done_s[k]}, {31'b0, pend[k]});
                pend[k] = 1'b0;
                if (!w_valid_s[k]) chk("w_idle", {31'b0, w_s[k]}, 0);
                else if (sbq[k].size() == 0) chk("w_extra", 1, 0);
                else begin
                    it = sbq[k].pop_front();
                    chk("w_bit", {31'b0, w_s[k]}, {31'b0, it[0]});
                    pend[k] = it[1];
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        ld[0] = '0; ld[1] = '0; ll[0] = '0; ll[1] = '0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_w", {31'b0, w_s[k]}, 0);
            chk("rst_w_valid", {31'b0, w_valid_s[k]}, 0);
            chk("rst_busy", {31'b0, busy_s[k]}, 0);
            chk("rst_done", {31'b0, done_s[k]}, 0);
            chk("rst_ready", {31'b0, load_ready_s[k]}, 1);
        end
        resetn = 1'b1;
        @(negedge clk);
        // basic 4-bit word with one gap cycle
        send(0, 8'h0D, 4'd4, 8'h0D, 4);
        repeat (4) @(negedge clk);
        chk("t1_done5", {31'b0, done_s[0]}, 1);
        chk("t1_ready5", {31'b0, load_ready_s[0]}, 0);
        chk("t1_busy5", {31'b0, busy_s[0]}, 1);
        chk("t1_wv5", {31'b0, w_valid_s[0]}, 0);
        @(negedge clk);
        chk("t1_ready6", {31'b0, load_ready_s[0]}, 1);
        chk("t1_busy6", {31'b0, busy_s[0]}, 0);
        // len 0 means full width
        send(0, 8'hA5, 4'd0, 8'hA5, 8);
        // load_valid held during SHIFT must be ignored
        send(0, 8'h96, 4'd8, 8'h96, 8);
        ld[0] = 8'hFF;
        ll[0] = 4'd8;
        lv[0] = 1'b1;
        repeat (6) @(negedge clk);
        lv[0] = 1'b0;
        send(0, 8'hFD, 4'd4, 8'h0D, 4);
        send(0, 8'h3C, 4'd9, 8'h3C, 8);
        send(0, 8'h01, 4'd1, 8'h01, 1);
        send(0, 8'h80, 4'd15, 8'h80, 8);
        // reset mid-word aborts it with no done
        send(0, 8'h0D, 4'd4, 8'h0D, 4);
        @(negedge clk);
        #2 resetn = 1'b0;
        sbq[0].delete();
        #1;
        chk("abort_w", {31'b0, w_s[0]}, 0);
        chk("abort_wv", {31'b0, w_valid_s[0]}, 0);
        chk("abort_busy", {31'b0, busy_s[0]}, 0);
        chk("abort_ready", {31'b0, load_ready_s[0]}, 1);
        chk("abort_done", {31'b0, done_s[0]}, 0);
        @(negedge clk);
        #2 resetn = 1'b1;
        @(negedge clk);
        send(0, 8'h0B, 4'd4, 8'h0B, 4);
        // back-to-back words with GAP_CYCLES=0
        send(1, 8'h0D, 4'd4, 8'h0D, 4);
        repeat (4) @(negedge clk);
        chk("b2b_idle_wv", {31'b0, w_valid_s[1]}, 0);
        chk("b2b_ready", {31'b0, load_ready_s[1]}, 1);
        send(1, 8'h0B, 4'd4, 8'h0B, 4);
`ifdef TX_REPEAT_EN
        repeat (8) @(negedge clk);
        rpt[0] = 1'b1;
        send(0, 8'h0D, 4'd4, 8'h0D, 4);
        push(0, 8'h0D, 4);
        push(0, 8'h0D, 4);
        repeat (4) @(negedge clk);
        chk("rep_ready", {31'b0, load_ready_s[0]}, 0);
        chk("rep_wv", {31'b0, w_valid_s[0]}, 1);
        repeat (4) @(negedge clk);
        rpt[0] = 1'b0;
`endif
        repeat (16) @(negedge clk);
        chk("q0_empty", sbq[0].size(), 0);
        chk("q1_empty", sbq[1].size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
